mem_arbiter: RTL and testbench

- Two-port to one-port arbiter between the fetch stage's instruction memory interface (imem, read-only) and the memory stage's data interface (dmem, read/write), in front of a single shared 128-bit line memory (pmem).
- Grants one whole transaction at a time using the same stb/cyc strobe style as the pipeline stages.
- dmem has fixed priority, with an anti-starvation streak limit for imem.
- Sits between the pipeline stages or L1 caches and the shared memory or L2.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - dmem-priority two-port to one-port line memory arbiter (optional ARB_PERF_CNT_EN perf counters)
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 128,
    parameter int DSTREAK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                imem_stb,
    input  logic                imem_cyc,
    input  logic [ADDR_W-1:0]   imem_address,
    output logic [LINE_W-1:0]   imem_rdata,
    output logic                imem_resp,
    input  logic                dmem_stb,
    input  logic                dmem_cyc,
    input  logic                dmem_we,
    input  logic [LINE_W/8-1:0] dmem_sel,
    input  logic [ADDR_W-1:0]   dmem_address,
    input  logic [LINE_W-1:0]   dmem_wdata,
    output logic [LINE_W-1:0]   dmem_rdata,
    output logic                dmem_resp,
    output logic                pmem_stb,
    output logic                pmem_cyc,
    output logic                pmem_we,
    output logic [LINE_W/8-1:0] pmem_sel,
    output logic [ADDR_W-1:0]   pmem_address,
    output logic [LINE_W-1:0]   pmem_wdata,
    input  logic [LINE_W-1:0]   pmem_rdata,
    input  logic                pmem_ack
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_imem_grants,
    output logic [31:0]         perf_dmem_grants,
    output logic [31:0]         perf_conflict_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(DSTREAK_MAX);

    state_t     state;
    state_t     state_next;
    logic       imem_req;
    logic       dmem_req;
    logic       grant_i;
    logic       grant_d;
    logic [3:0] streak;

    assign imem_req = imem_stb & imem_cyc;
    assign dmem_req = dmem_stb & dmem_cyc;

    // Read data is broadcast to both ports; only resp marks it as belonging to a port.
    assign imem_rdata = pmem_rdata;
    assign dmem_rdata = pmem_rdata;
    assign imem_resp  = pmem_ack && (state == BUSY_I);
    assign dmem_resp  = pmem_ack && (state == BUSY_D);

    // Arbitration and transaction sequencing: dmem wins unless imem has waited out a full streak.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (dmem_req && (!imem_req || (streak < STREAK_MAX))) begin
                    state_next = BUSY_D;
                    grant_d    = 1'b1;
                end else if (imem_req) begin
                    state_next = BUSY_I;
                    grant_i    = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (pmem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the winner's request into the shared port; strobes stay up for the whole grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pmem_stb     <= 1'b0;
            pmem_cyc     <= 1'b0;
            pmem_we      <= 1'b0;
            pmem_sel     <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            pmem_stb <= (state_next != IDLE);
            pmem_cyc <= (state_next != IDLE);
            if (grant_d) begin
                pmem_address <= {dmem_address[ADDR_W-1:4], 4'b0000};
                pmem_we      <= dmem_we;
                pmem_sel     <= dmem_sel;
                pmem_wdata   <= dmem_wdata;
            end else if (grant_i) begin
                pmem_address <= {imem_address[ADDR_W-1:4], 4'b0000};
                pmem_we      <= 1'b0;
                pmem_sel     <= '1;
                pmem_wdata   <= '0;
            end
        end
    end

    // Count dmem grants that jumped ahead of a waiting imem; any grant without contention resets it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak <= 4'd0;
        end else if (grant_i) begin
            streak <= 4'd0;
        end else if (grant_d) begin
            if (!imem_req) begin
                streak <= 4'd0;
            end else if (streak >= STREAK_MAX) begin
                streak <= STREAK_MAX;
            end else begin
                streak <= streak + 4'd1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Grant and contention statistics; counters wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_imem_grants     <= 32'd0;
            perf_dmem_grants     <= 32'd0;
            perf_conflict_cycles <= 32'd0;
        end else begin
            if (grant_i) begin
                perf_imem_grants <= perf_imem_grants + 32'd1;
            end
            if (grant_d) begin
                perf_dmem_grants <= perf_dmem_grants + 32'd1;
            end
            if (imem_req && dmem_req && (state != BUSY_I)) begin
                perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         imem_stb;
    logic         imem_cyc;
    logic [15:0]  imem_address;
    logic [127:0] imem_rdata;
    logic         imem_resp;
    logic         dmem_stb;
    logic         dmem_cyc;
    logic         dmem_we;
    logic [15:0]  dmem_sel;
    logic [15:0]  dmem_address;
    logic [127:0] dmem_wdata;
    logic [127:0] dmem_rdata;
    logic         dmem_resp;
    logic         pmem_stb;
    logic         pmem_cyc;
    logic         pmem_we;
    logic [15:0]  pmem_sel;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_ack;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]  perf_imem_grants;
    logic [31:0]  perf_dmem_grants;
    logic [31:0]  perf_conflict_cycles;
`endif

    int vectors;
    int miscompares;

    mem_arbiter #(
        .ADDR_W      (16),
        .LINE_W      (128),
        .DSTREAK_MAX (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_stb     (imem_stb),
        .imem_cyc     (imem_cyc),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_stb     (dmem_stb),
        .dmem_cyc     (dmem_cyc),
        .dmem_we      (dmem_we),
        .dmem_sel     (dmem_sel),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .pmem_stb     (pmem_stb),
        .pmem_cyc     (pmem_cyc),
        .pmem_we      (pmem_we),
        .pmem_sel     (pmem_sel),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_ack     (pmem_ack)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_imem_grants     (perf_imem_grants),
        .perf_dmem_grants     (perf_dmem_grants),
        .perf_conflict_cycles (perf_conflict_cycles)
`endif
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_addr [6];
        logic        exp_is_i [6];

        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        imem_stb     = 1'b0;
        imem_cyc     = 1'b0;
        imem_address = 16'h0;
        dmem_stb     = 1'b0;
        dmem_cyc     = 1'b0;
        dmem_we      = 1'b0;
        dmem_sel     = 16'h0;
        dmem_address = 16'h0;
        dmem_wdata   = 128'h0;
        pmem_rdata   = 128'h0;
        pmem_ack     = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_stb",  128'(pmem_stb), 128'(0));
        chk("rst_cyc",  128'(pmem_cyc), 128'(0));
        chk("rst_we",   128'(pmem_we), 128'(0));
        chk("rst_sel",  128'(pmem_sel), 128'(0));
        chk("rst_addr", 128'(pmem_address), 128'(0));
        chk("rst_wdata", pmem_wdata, 128'h0);
        chk("rst_iresp", 128'(imem_resp), 128'(0));
        chk("rst_dresp", 128'(dmem_resp), 128'(0));
        rst_n = 1'b1;
        step();

        // Single imem read, ack three cycles after pmem_stb
        imem_stb = 1'b1; imem_cyc = 1'b1; imem_address = 16'h1236;
        step();
        chk("i1_stb",  128'(pmem_stb), 128'(1));
        chk("i1_cyc",  128'(pmem_cyc), 128'(1));
        chk("i1_addr", 128'(pmem_address), 128'(16'h1230));
        chk("i1_we",   128'(pmem_we), 128'(0));
        chk("i1_sel",  128'(pmem_sel), 128'(16'hFFFF));
        chk("i1_early_resp", 128'(imem_resp), 128'(0));
        step();
        step();
        chk("i1_hold_stb", 128'(pmem_stb), 128'(1));
        step();
        pmem_ack = 1'b1; pmem_rdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        #1;
        chk("i1_resp",  128'(imem_resp), 128'(1));
        chk("i1_rdata", imem_rdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        chk("i1_dresp", 128'(dmem_resp), 128'(0));
        step();
        pmem_ack = 1'b0; imem_stb = 1'b0; imem_cyc = 1'b0;
        #1;
        chk("i1_resp_width", 128'(imem_resp), 128'(0));
        chk("i1_stb_drop", 128'(pmem_stb), 128'(0));

        // Simultaneous requests: dmem write first, idle gap, then imem
        dmem_stb = 1'b1; dmem_cyc = 1'b1; dmem_we = 1'b1; dmem_sel = 16'h00F0;
        dmem_address = 16'h2000; dmem_wdata = 128'h11112222_33334444_55556666_77778888;
        imem_stb = 1'b1; imem_cyc = 1'b1; imem_address = 16'h3004;
        step();
        chk("c_d_addr",  128'(pmem_address), 128'(16'h2000));
        chk("c_d_we",    128'(pmem_we), 128'(1));
        chk("c_d_sel",   128'(pmem_sel), 128'(16'h00F0));
        chk("c_d_wdata", pmem_wdata, 128'h11112222_33334444_55556666_77778888);
        pmem_ack = 1'b1;
        #1;
        chk("c_d_resp", 128'(dmem_resp), 128'(1));
        chk("c_i_noresp", 128'(imem_resp), 128'(0));
        step();
        pmem_ack = 1'b0; dmem_stb = 1'b0; dmem_cyc = 1'b0; dmem_we = 1'b0;
        #1;
        chk("c_idle_gap", 128'(pmem_stb), 128'(0));
        step();
        chk("c_i_stb",  128'(pmem_stb), 128'(1));
        chk("c_i_addr", 128'(pmem_address), 128'(16'h3000));
        chk("c_i_we",   128'(pmem_we), 128'(0));
        pmem_ack = 1'b1;
        #1;
        chk("c_i_resp", 128'(imem_resp), 128'(1));
        step();
        pmem_ack = 1'b0; imem_stb = 1'b0; imem_cyc = 1'b0;

        // Streak limit: D,D,D,D,I,D with dmem continuously requesting
        exp_addr[0] = 16'h4000; exp_is_i[0] = 1'b0;
        exp_addr[1] = 16'h4000; exp_is_i[1] = 1'b0;
        exp_addr[2] = 16'h4000; exp_is_i[2] = 1'b0;
        exp_addr[3] = 16'h4000; exp_is_i[3] = 1'b0;
        exp_addr[4] = 16'h5000; exp_is_i[4] = 1'b1;
        exp_addr[5] = 16'h4000; exp_is_i[5] = 1'b0;
        dmem_stb = 1'b1; dmem_cyc = 1'b1; dmem_we = 1'b0; dmem_sel = 16'hFFFF;
        dmem_address = 16'h400C;
        imem_stb = 1'b1; imem_cyc = 1'b1; imem_address = 16'h500A;
        for (int g = 0; g < 6; g++) begin
            step();
            chk($sformatf("s_addr%0d", g), 128'(pmem_address), 128'(exp_addr[g]));
            pmem_ack = 1'b1;
            #1;
            chk($sformatf("s_iresp%0d", g), 128'(imem_resp), 128'(exp_is_i[g]));
            chk($sformatf("s_dresp%0d", g), 128'(dmem_resp), 128'(!exp_is_i[g]));
            step();
            pmem_ack = 1'b0;
            if (exp_is_i[g]) begin
                imem_stb = 1'b0; imem_cyc = 1'b0;
            end
        end
        dmem_stb = 1'b0; dmem_cyc = 1'b0;
        step();

        // Reset in the middle of a dmem grant
        dmem_stb = 1'b1; dmem_cyc = 1'b1; dmem_address = 16'h6008;
        step();
        chk("r_busy_stb", 128'(pmem_stb), 128'(1));
        rst_n = 1'b0;
        step();
        chk("r_stb",   128'(pmem_stb), 128'(0));
        chk("r_cyc",   128'(pmem_cyc), 128'(0));
        chk("r_addr",  128'(pmem_address), 128'(0));
        chk("r_dresp", 128'(dmem_resp), 128'(0));
        rst_n = 1'b1;
        step();
        chk("r_regrant_stb",  128'(pmem_stb), 128'(1));
        chk("r_regrant_addr", 128'(pmem_address), 128'(16'h6000));
        pmem_ack = 1'b1;
        #1;
        chk("r_dresp_after", 128'(dmem_resp), 128'(1));
        step();
        pmem_ack = 1'b0; dmem_stb = 1'b0; dmem_cyc = 1'b0;
        step();

        // Spurious ack while idle
        pmem_ack = 1'b1;
        #1;
        chk("sp_iresp", 128'(imem_resp), 128'(0));
        chk("sp_dresp", 128'(dmem_resp), 128'(0));
        step();
        pmem_ack = 1'b0;
        #1;
        chk("sp_stb", 128'(pmem_stb), 128'(0));
        step();
        chk("sp_stb2", 128'(pmem_stb), 128'(0));

`ifdef ARB_PERF_CNT_EN
        // Perf counters: 2 imem, 3 dmem grants, 4 overlap cycles
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("p_rst_i", 128'(perf_imem_grants), 128'(0));
        for (int p = 0; p < 2; p++) begin
            dmem_stb = 1'b1; dmem_cyc = 1'b1; dmem_address = 16'h7000;
            imem_stb = 1'b1; imem_cyc = 1'b1; imem_address = 16'h8000;
            step();
            pmem_ack = 1'b1;
            step();
            pmem_ack = 1'b0; dmem_stb = 1'b0; dmem_cyc = 1'b0;
            step();
            pmem_ack = 1'b1;
            step();
            pmem_ack = 1'b0; imem_stb = 1'b0; imem_cyc = 1'b0;
        end
        dmem_stb = 1'b1; dmem_cyc = 1'b1;
        step();
        pmem_ack = 1'b1;
        step();
        pmem_ack = 1'b0; dmem_stb = 1'b0; dmem_cyc = 1'b0;
        step();
        chk("p_imem",     128'(perf_imem_grants), 128'(2));
        chk("p_dmem",     128'(perf_dmem_grants), 128'(3));
        chk("p_conflict", 128'(perf_conflict_cycles), 128'(4));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
